ps2_scan_rx: RTL and testbench

PS/2 receive front end that turns raw `kbclk`/`kbdat` line activity into complete, validated scan-code events for the keyboard decode stage. It synchronises and de-glitches the PS/2 lines, deframes 11-bit frames, and absorbs `E0` (extended) and `F0` (break) prefixes. Each key event is reported as one `scan_code_ready` pulse with `key_extended`/`key_break` qualifiers, so the decoder never sees prefix bytes as keys.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_line_filter.sv | 61 ++++++
 rtl/ps2_scan_rx.sv | 157 +++++++++++++++
 tb/tb_ps2_scan_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and parity helper for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  // PS/2 uses odd parity across the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Line conditioning: 2-flop synchronisers on both PS/2 lines, saturating glitch
// filter and falling-edge strobe on the clock line; the data line bypasses the filter.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic kbclk_i,
  input  logic kbdat_i,
  output logic clk_fall_o,
  output logic dat_sync_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic [CW-1:0] flt_cnt_q, flt_cnt_d;
  logic          flt_lvl_q, flt_lvl_d;
  logic          fall_q, fall_d;
  logic          sample;

  assign sample = clk_sync_q[1];

  always_comb begin
    clk_sync_d = {clk_sync_q[0], kbclk_i};
    dat_sync_d = {dat_sync_q[0], kbdat_i};
    flt_cnt_d  = '0;
    flt_lvl_d  = flt_lvl_q;
    fall_d     = 1'b0;
    // The level flips only on the FILTER_LEN-th consecutive differing sample.
    if (sample != flt_lvl_q) begin
      if (flt_cnt_q == CW'(FILTER_LEN - 1)) begin
        flt_lvl_d = sample;
        fall_d    = ~sample;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      flt_cnt_q  <= '0;
      flt_lvl_q  <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      flt_cnt_q  <= flt_cnt_d;
      flt_lvl_q  <= flt_lvl_d;
      fall_q     <= fall_d;
    end
  end

  assign clk_fall_o = fall_q;
  assign dat_sync_o = dat_sync_q[1];

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 receive front end: deframes 11-bit frames and folds E0/F0 prefixes into key events.
// Define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbclk,
  input  logic       kbdat,
  output logic [7:0] scan_code,
  output logic       scan_code_ready,
  output logic       key_break,
  output logic       key_extended,
  output logic       frame_error,
  output ps2_state_e dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_IGNORE = 1'b0;
`else
  localparam logic PARITY_IGNORE = 1'b1;
`endif

  logic fall, dat;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk        (clk),
    .reset      (reset),
    .kbclk_i    (kbclk),
    .kbdat_i    (kbdat),
    .clk_fall_o (fall),
    .dat_sync_o (dat)
  );

  ps2_state_e    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [7:0]    scan_q, scan_d;
  logic          ready_q, ready_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          err_q, err_d;
  logic          frame_ok;

  // Start bit is validated on entry to DATA, so only stop and parity remain.
  assign frame_ok = dat & (PARITY_IGNORE | odd_parity_ok(shift_q[7:0], shift_q[8]));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tmo_d      = tmo_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    scan_d     = scan_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d     = '0;
        bit_cnt_d = '0;
        if (fall && !dat) begin
          state_d   = ST_DATA;
          bit_cnt_d = 4'd1;
        end
      end
      ST_DATA: begin
        if (fall) begin
          tmo_d     = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q != 4'(PS2_FRAME_BITS - 1)) begin
            // Data bits then parity shift in from the top: LSB ends at bit 0.
            shift_d = {dat, shift_q[8:1]};
          end else begin
            state_d = ST_CHECK;
            // Outputs are registered here so they appear in the CHECK cycle.
            if (!frame_ok) begin
              err_d      = 1'b1;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end else if (shift_q[7:0] == PS2_EXT_PREFIX) begin
              ext_pend_d = 1'b1;
            end else if (shift_q[7:0] == PS2_BREAK_PREFIX) begin
              brk_pend_d = 1'b1;
            end else begin
              scan_d     = shift_q[7:0];
              brk_d      = brk_pend_q;
              ext_d      = ext_pend_q;
              ready_d    = 1'b1;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          tmo_d      = '0;
          bit_cnt_d  = '0;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CHECK: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      scan_q     <= '0;
      ready_q    <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      scan_q     <= scan_d;
      ready_q    <= ready_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      err_q      <= err_d;
    end
  end

  assign scan_code       = scan_q;
  assign scan_code_ready = ready_q;
  assign key_break       = brk_q;
  assign key_extended    = ext_q;
  assign frame_error     = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: PS/2 frame driver, scoreboard of expected key events.
module tb_ps2_scan_rx;
  import ps2_pkg::*;

  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kbclk = 1'b1;
  logic       kbdat = 1'b1;
  logic [7:0] scan_code;
  logic       scan_code_ready, key_break, key_extended, frame_error;
  ps2_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int exp_err = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_v;
  logic [9:0] last_v = '0;

  ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .kbclk           (kbclk),
    .kbdat           (kbdat),
    .scan_code       (scan_code),
    .scan_code_ready (scan_code_ready),
    .key_break       (key_break),
    .key_extended    (key_extended),
    .frame_error     (frame_error),
    .dbg_state       (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // monitor / scoreboard: event layout is {break, extended, code}
  always @(negedge clk) begin
    if (frame_error) err_seen++;
    if (scan_code_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_ready got=%h required=none", {key_break, key_extended, scan_code});
      end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        assert ({key_break, key_extended, scan_code} === exp_v) else begin
          errors++;
          $error("FAIL key_event got=%h required=%h", {key_break, key_extended, scan_code}, exp_v);
        end
        last_v = exp_v;
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    kbdat = b;
    wait_cyc(10);
    if (glitch) begin
      kbclk = 1'b0;
      wait_cyc(3);
      kbclk = 1'b1;
    end
    wait_cyc(10);
    kbclk = 1'b0;
    wait_cyc(40);
    kbclk = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                            input int glitch_at, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_at);
    kbdat = 1'b1;
    wait_cyc(5);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b0, -1, PS2_FRAME_BITS);
  endtask

  task automatic expect_key(input logic [7:0] code, input logic brk, input logic ext);
    exp_q.push_back({brk, ext, code});
  endtask

  task automatic check_drained(input string tag);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s pending_events got=%0d required=0", tag, exp_q.size());
    end
  endtask

  task automatic check_err(input string tag);
    checks++;
    assert (err_seen === exp_err) else begin
      errors++;
      $error("FAIL %s frame_errors got=%0d required=%0d", tag, err_seen, exp_err);
    end
  endtask

  task automatic check_hold(input string tag);
    checks++;
    assert ({key_break, key_extended, scan_code} === last_v) else begin
      errors++;
      $error("FAIL %s held_outputs got=%h required=%h", tag,
             {key_break, key_extended, scan_code}, last_v);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    assert ({scan_code, scan_code_ready, key_break, key_extended, frame_error} === 12'h000) else begin
      errors++;
      $error("FAIL %s outputs got=%h required=000", tag,
             {scan_code, scan_code_ready, key_break, key_extended, frame_error});
    end
    checks++;
    assert (dbg_state === ST_IDLE) else begin
      errors++;
      $error("FAIL %s state got=%0d required=%0d", tag, dbg_state, ST_IDLE);
    end
  endtask

  // directed sequence
  initial begin
    wait_cyc(5);
    check_reset_state("reset");
    rst_n = 1'b1;
    wait_cyc(5);

    expect_key(8'h1D, 1'b0, 1'b0);
    send_byte(8'h1D);
    check_drained("make_1d");
    check_hold("make_1d");

    send_byte(8'hF0);
    expect_key(8'h1D, 1'b1, 1'b0);
    send_byte(8'h1D);
    check_drained("break_1d");

    send_byte(8'hE0);
    send_byte(8'hF0);
    expect_key(8'h75, 1'b1, 1'b1);
    send_byte(8'h75);
    check_drained("ext_break_75");
    expect_key(8'h75, 1'b0, 1'b0);
    send_byte(8'h75);
    check_drained("plain_75");

    send_byte(8'hE0);
    send_byte(8'hE0);
    expect_key(8'h6B, 1'b0, 1'b1);
    send_byte(8'h6B);
    check_drained("double_e0");

`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h29, 1'b1, 1'b0, -1, PS2_FRAME_BITS);
    exp_err++;
`else
    expect_key(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b1, 1'b0, -1, PS2_FRAME_BITS);
`endif
    check_drained("bad_parity_29");
    check_err("bad_parity_29");
    check_hold("bad_parity_29");

    send_byte(8'hF0);
    send_frame(8'h3A, 1'b0, 1'b1, -1, PS2_FRAME_BITS);
    exp_err++;
    check_err("bad_stop");
    check_hold("bad_stop");
    expect_key(8'h3A, 1'b0, 1'b0);
    send_byte(8'h3A);
    check_drained("after_bad_stop");

    send_byte(8'hE0);
    send_frame(8'h00, 1'b0, 1'b0, -1, 5);
    wait_cyc(TMO + 1000);
    exp_err++;
    check_err("timeout");
    check_hold("timeout");
    expect_key(8'h2D, 1'b0, 1'b0);
    send_byte(8'h2D);
    check_drained("after_timeout_2d");

    expect_key(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 4, PS2_FRAME_BITS);
    check_drained("glitch_3c");
    check_err("glitch_3c");

    send_byte(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b0, -1, 4);
    rst_n = 1'b0;
    wait_cyc(3);
    check_reset_state("mid_frame_reset");
    last_v = '0;
    rst_n = 1'b1;
    wait_cyc(5);
    expect_key(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    check_drained("after_reset_1c");
    check_err("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
